jtexterm_sub_bus: RTL and testbench

Bus controller for the sound (sub) CPU of the exterm core. It sits between the sub-CPU Z80 bus and the sub side of the main/sub shared communication RAM (the `shr_*` port), the sub-CPU program ROM, and the FM sound chip. It sequences every sub-CPU memory access with wait states, generates the periodic sound IRQ, and holds the sub CPU in reset under control of the main CPU's `snd_rstn`.

---
 rtl/jtexterm_sub_bus_if.sv | 24 ++
 rtl/jtexterm_sub_bus.sv | 162 ++++++++++++++++
 tb/tb_jtexterm_sub_bus.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtexterm_sub_bus_if.sv
// Sub Z80 bus bundle for the exterm sound CPU: address, strobes, data and
// the WAIT/INT lines returned by the bus controller.
interface jtexterm_sub_bus_if;
   logic [15:0] A;
   logic        mreq_n;
   logic        iorq_n;
   logic        m1_n;
   logic        rd_n;
   logic        wr_n;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        wait_n;
   logic        int_n;

   modport master (
      output A, mreq_n, iorq_n, m1_n, rd_n, wr_n, cpu_dout,
      input  cpu_din, wait_n, int_n
   );

   modport slave (
      input  A, mreq_n, iorq_n, m1_n, rd_n, wr_n, cpu_dout,
      output cpu_din, wait_n, int_n
   );
endinterface

// File: rtl/jtexterm_sub_bus.sv
// Sound (sub) CPU bus controller for exterm: sequences Z80 accesses to ROM,
// shared RAM and FM with wait states, and owns the sound IRQ and sub reset.
module jtexterm_sub_bus #(
   parameter logic [15:0] IRQ_DIV     = 16'd24000,
   parameter logic [4:0]  RST_STRETCH = 5'd16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        snd_rstn,
   output logic        cpu_rstn,
   jtexterm_sub_bus_if.slave bus,
   output logic [12:0] shr_addr,
   output logic [7:0]  shr_din,
   output logic        shr_we,
   input  logic [7:0]  shr_dout,
   output logic [14:0] rom_addr,
   output logic        rom_cs,
   input  logic        rom_ok,
   input  logic [7:0]  rom_data,
   output logic        fm_cs,
   output logic        fm_wrn,
   input  logic [7:0]  fm_dout
);
   typedef enum logic [3:0] {
      IDLE, ROM0, ROM, SRD0, SRD, SWR, FM0, FM, NUL, END
   } state_t;

   state_t      state, state_nxt;
   logic        snd_s1, snd_s2, abort;
   logic [4:0]  rst_cnt;
   logic [15:0] irq_cnt;
   logic        irq_set, irq_ack, int_r;
   logic        done, done_nxt;
   logic [7:0]  din_r, din_nxt;
   logic        access_active, start, is_wr;
   logic        rom_sel, shr_sel, fm_sel;

   assign shr_addr = bus.A[12:0];
   assign shr_din  = bus.cpu_dout;
   assign rom_addr = bus.A[14:0];
   assign fm_wrn   = bus.wr_n;

   assign rom_sel = !bus.A[15];
   assign shr_sel = bus.A[15:13] == 3'b100;
   assign fm_sel  = bus.A[15:1] == 15'h5000;
   assign is_wr   = !bus.wr_n;

   assign access_active = !bus.mreq_n && (!bus.rd_n || !bus.wr_n);
   assign start         = access_active && state == IDLE && !done;

   // The raw request is used alongside the synchronised one so that a reset
   // arriving on the start edge already suppresses the strobes.
   assign abort = !snd_s2 || !snd_rstn;

   assign bus.wait_n = !(access_active && !done && !abort);
   assign bus.int_n  = int_r;
   assign bus.cpu_din = din_r;
   assign rom_cs = state == ROM0 || state == ROM;
   assign shr_we = state == SWR && !abort;
   assign fm_cs  = state == FM0 && !abort;

   // Sub reset: 2-flop sync plus a stretch counted in cen pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snd_s1  <= 1'b0;
         snd_s2  <= 1'b0;
         rst_cnt <= '0;
      end else begin
         snd_s1 <= snd_rstn;
         snd_s2 <= snd_s1;
         if (!snd_s2)
            rst_cnt <= RST_STRETCH;
         else if (cen && rst_cnt != '0)
            rst_cnt <= rst_cnt - 5'd1;
      end
   end

   assign cpu_rstn = snd_s2 && rst_cnt == '0;

   assign irq_ack = !bus.iorq_n && !bus.m1_n;
   assign irq_set = cen && irq_cnt == IRQ_DIV - 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_cnt <= '0;
         int_r   <= 1'b1;
      end else if (!snd_s2) begin
         irq_cnt <= '0;
         int_r   <= 1'b1;
      end else begin
         if (cen)
            irq_cnt <= irq_set ? '0 : irq_cnt + 16'd1;
         if (irq_ack)
            int_r <= 1'b1;
         else if (irq_set)
            int_r <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
         din_r <= '1;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         din_r <= din_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = done;
      din_nxt   = din_r;
      if (bus.mreq_n)
         done_nxt = 1'b0;
      case (state)
         IDLE: if (start) begin
            if (rom_sel)      state_nxt = is_wr ? NUL : ROM0;
            else if (shr_sel) state_nxt = is_wr ? SWR : SRD0;
            else if (fm_sel)  state_nxt = FM0;
            else              state_nxt = NUL;
         end
         ROM0: state_nxt = ROM;
         ROM: if (rom_ok) begin
            din_nxt   = rom_data;
            done_nxt  = 1'b1;
            state_nxt = END;
         end
         SRD0: state_nxt = SRD;
         SRD: begin
            din_nxt   = shr_dout;
            done_nxt  = 1'b1;
            state_nxt = END;
         end
         SWR: begin
            done_nxt  = 1'b1;
            state_nxt = END;
         end
         FM0: state_nxt = FM;
         FM: begin
            if (!bus.rd_n)
               din_nxt = fm_dout;
            done_nxt  = 1'b1;
            state_nxt = END;
         end
         NUL: begin
            din_nxt   = 8'hFF;
            done_nxt  = 1'b1;
            state_nxt = END;
         end
         END: if (bus.mreq_n) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
         done_nxt  = 1'b0;
      end
   end
endmodule

// File: tb/tb_jtexterm_sub_bus.sv
// Directed bench for jtexterm_sub_bus: vector table of bus accesses plus
// hand-written ROM handshake, long write, IRQ and sub-reset sequences.
module tb_jtexterm_sub_bus;
   logic        clk = 1'b0;
   logic        rst, cen, snd_rstn, cpu_rstn;
   logic [12:0] shr_addr;
   logic [7:0]  shr_din, shr_dout, rom_data, fm_dout;
   logic        shr_we, rom_cs, rom_ok, fm_cs, fm_wrn;
   logic [14:0] rom_addr;

   jtexterm_sub_bus_if bus_i();

   jtexterm_sub_bus #(.IRQ_DIV(16'd10), .RST_STRETCH(5'd16)) dut (
      .clk(clk), .rst(rst), .cen(cen), .snd_rstn(snd_rstn), .cpu_rstn(cpu_rstn),
      .bus(bus_i.slave),
      .shr_addr(shr_addr), .shr_din(shr_din), .shr_we(shr_we), .shr_dout(shr_dout),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
      .fm_cs(fm_cs), .fm_wrn(fm_wrn), .fm_dout(fm_dout)
   );

   always #5 clk = ~clk;

   // Shared RAM model (1 clk read latency) and strobe monitors
   logic [7:0]  mem [8192];
   int          we_cnt = 0, fm_cnt = 0;
   logic [12:0] we_addr;
   logic [7:0]  we_data;
   logic        fm_wrn_seen;

   always @(posedge clk) begin
      if (shr_we) begin
         mem[shr_addr] <= shr_din;
         we_cnt  <= we_cnt + 1;
         we_addr <= shr_addr;
         we_data <= shr_din;
      end
      if (fm_cs) begin
         fm_cnt      <= fm_cnt + 1;
         fm_wrn_seen <= fm_wrn;
      end
      shr_dout <= mem[shr_addr];
   end

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic access(input logic [15:0] a, input logic wr, input logic [7:0] d,
                         output int waits, output logic [7:0] din);
      bus_i.A = a;
      bus_i.cpu_dout = d;
      bus_i.mreq_n = 1'b0;
      if (wr) bus_i.wr_n = 1'b0;
      else    bus_i.rd_n = 1'b0;
      waits = 0;
      #1;
      while (!bus_i.wait_n && waits < 50) begin
         waits++;
         @(negedge clk);
         #1;
      end
      din = bus_i.cpu_din;
      bus_i.mreq_n = 1'b1;
      bus_i.rd_n   = 1'b1;
      bus_i.wr_n   = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] a;
      logic        wr;
      logic [7:0]  d;
      logic [7:0]  din;
      int          waits;
      int          we;
      int          fm;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int          waits, k, lows, we0, fm0;
      logic [7:0]  din;
      logic        found;

      vecs[0]  = '{16'h8123, 1'b1, 8'h5A, 8'h00, 2, 1, 0};
      vecs[1]  = '{16'h8123, 1'b0, 8'h00, 8'h5A, 3, 0, 0};
      vecs[2]  = '{16'hC000, 1'b0, 8'h00, 8'hFF, 2, 0, 0};
      vecs[3]  = '{16'hC000, 1'b1, 8'h33, 8'h00, 2, 0, 0};
      vecs[4]  = '{16'h1234, 1'b0, 8'h00, 8'h6E, 3, 0, 0};
      vecs[5]  = '{16'h0100, 1'b1, 8'h11, 8'h00, 2, 0, 0};
      vecs[6]  = '{16'hA001, 1'b1, 8'h44, 8'h00, 3, 0, 1};
      vecs[7]  = '{16'hA000, 1'b0, 8'h00, 8'h77, 3, 0, 1};
      vecs[8]  = '{16'hA002, 1'b0, 8'h00, 8'hFF, 2, 0, 0};
      vecs[9]  = '{16'h8000, 1'b1, 8'hC3, 8'h00, 2, 1, 0};
      vecs[10] = '{16'h8000, 1'b0, 8'h00, 8'hC3, 3, 0, 0};
      vecs[11] = '{16'h7FFF, 1'b0, 8'h00, 8'h9E, 3, 0, 0};

      rst = 1'b1; cen = 1'b1; snd_rstn = 1'b1;
      rom_ok = 1'b1; rom_data = 8'h00; fm_dout = 8'h77;
      bus_i.A = '0; bus_i.cpu_dout = '0;
      bus_i.mreq_n = 1'b1; bus_i.iorq_n = 1'b1; bus_i.m1_n = 1'b1;
      bus_i.rd_n = 1'b1; bus_i.wr_n = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst cpu_rstn", int'(cpu_rstn), 0);
      chk("rst wait_n", int'(bus_i.wait_n), 1);
      chk("rst int_n", int'(bus_i.int_n), 1);
      chk("rst shr_we", int'(shr_we), 0);
      chk("rst rom_cs", int'(rom_cs), 0);
      chk("rst fm_cs", int'(fm_cs), 0);
      chk("rst cpu_din", int'(bus_i.cpu_din), 8'hFF);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("boot cpu_rstn", int'(cpu_rstn), 1);

      foreach (vecs[i]) begin
         we0 = we_cnt; fm0 = fm_cnt;
         rom_data = vecs[i].din;
         access(vecs[i].a, vecs[i].wr, vecs[i].d, waits, din);
         chk($sformatf("v%0d waits", i), waits, vecs[i].waits);
         if (!vecs[i].wr) chk($sformatf("v%0d din", i), int'(din), int'(vecs[i].din));
         chk($sformatf("v%0d shr_we pulses", i), we_cnt - we0, vecs[i].we);
         chk($sformatf("v%0d fm_cs pulses", i), fm_cnt - fm0, vecs[i].fm);
         if (vecs[i].we != 0) begin
            chk($sformatf("v%0d shr_addr", i), int'(we_addr), int'(vecs[i].a[12:0]));
            chk($sformatf("v%0d shr_din", i), int'(we_data), int'(vecs[i].d));
         end
         if (vecs[i].fm != 0)
            chk($sformatf("v%0d fm_wrn", i), int'(fm_wrn_seen), int'(!vecs[i].wr));
      end

      // ROM handshake: rom_ok high on the first ROM cycle must be ignored
      rom_ok = 1'b1; rom_data = 8'h00;
      bus_i.A = 16'h0042; bus_i.mreq_n = 1'b0; bus_i.rd_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rom first ok ignored", int'(bus_i.wait_n), 0);
      chk("rom_cs", int'(rom_cs), 1);
      rom_ok = 1'b0;
      lows = 0;
      repeat (5) begin
         @(negedge clk);
         if (!bus_i.wait_n) lows++;
      end
      chk("rom wait while !ok", lows, 5);
      rom_ok = 1'b1; rom_data = 8'hC3;
      @(negedge clk);
      chk("rom wait_n after ok", int'(bus_i.wait_n), 1);
      chk("rom cpu_din", int'(bus_i.cpu_din), 8'hC3);
      bus_i.mreq_n = 1'b1; bus_i.rd_n = 1'b1;
      repeat (2) @(negedge clk);

      // Long write: one shr_we pulse per bus cycle
      we0 = we_cnt;
      bus_i.A = 16'h9FFF; bus_i.cpu_dout = 8'h0F; bus_i.mreq_n = 1'b0; bus_i.wr_n = 1'b0;
      repeat (20) @(negedge clk);
      bus_i.mreq_n = 1'b1; bus_i.wr_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("long wr pulses", we_cnt - we0, 1);
      chk("long wr addr", int'(we_addr), 13'h1FFF);
      access(16'h9FFF, 1'b0, 8'h00, waits, din);
      chk("long wr readback", int'(din), 8'h0F);

      // IRQ: 10 cen after the sub comes out of sync reset, plus 2 sync clk
      snd_rstn = 1'b0;
      repeat (4) @(negedge clk);
      snd_rstn = 1'b1;
      k = 0; found = 1'b0;
      while (!found && k < 40) begin
         @(negedge clk);
         k++;
         if (!bus_i.int_n) found = 1'b1;
      end
      chk("irq fall delay", k, 12);
      bus_i.iorq_n = 1'b0; bus_i.m1_n = 1'b0;
      @(negedge clk);
      chk("irq ack", int'(bus_i.int_n), 1);
      repeat (9) @(negedge clk);
      bus_i.iorq_n = 1'b1; bus_i.m1_n = 1'b1;
      chk("irq set+ack clear wins", int'(bus_i.int_n), 1);
      lows = 0;
      repeat (9) begin
         @(negedge clk);
         if (!bus_i.int_n) lows++;
      end
      chk("irq lost stays high", lows, 0);
      @(negedge clk);
      chk("irq next period", int'(bus_i.int_n), 0);
      bus_i.iorq_n = 1'b0; bus_i.m1_n = 1'b0;
      @(negedge clk);
      bus_i.iorq_n = 1'b1; bus_i.m1_n = 1'b1;

      // Sub reset dropped on the start of a shared RAM write
      we0 = we_cnt;
      bus_i.A = 16'h8000; bus_i.cpu_dout = 8'h99;
      bus_i.mreq_n = 1'b0; bus_i.wr_n = 1'b0; snd_rstn = 1'b0;
      #1;
      lows = bus_i.wait_n ? 0 : 1;
      repeat (4) begin
         @(negedge clk);
         if (!bus_i.wait_n) lows++;
      end
      chk("abort wait_n low count", lows, 0);
      chk("abort cpu_rstn", int'(cpu_rstn), 0);
      bus_i.mreq_n = 1'b1; bus_i.wr_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort no shr_we", we_cnt - we0, 0);
      snd_rstn = 1'b1;
      k = 0; found = 1'b0;
      while (!found && k < 60) begin
         @(negedge clk);
         k++;
         if (cpu_rstn) found = 1'b1;
      end
      chk("rst stretch clk", k, 18);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
